// File: rtl/wb_snoop_mem_slave_if.sv
// Wishbone B4 pipelined slave bus plus the write-snoop broadcast used by
// wb_snoop_mem_slave. The master modport drives requests and observes
// responses and snoops; the slave modport is the memory side.
interface wb_snoop_mem_slave_if;
  logic        cyc_i;
  logic        stb_i;
  logic        we_i;
  logic [31:0] adr_i;
  logic [31:0] dat_i;
  logic [3:0]  sel_i;
  logic [31:0] dat_o;
  logic        ack_o;
  logic        err_o;
  logic        stall_o;
  logic [31:0] snoop_addr_o;
  logic        snoop_valid_o;

  modport master (
    output cyc_i, stb_i, we_i, adr_i, dat_i, sel_i,
    input  dat_o, ack_o, err_o, stall_o, snoop_addr_o, snoop_valid_o
  );

  modport slave (
    input  cyc_i, stb_i, we_i, adr_i, dat_i, sel_i,
    output dat_o, ack_o, err_o, stall_o, snoop_addr_o, snoop_valid_o
  );
endinterface

// File: rtl/wb_snoop_mem_slave.sv
// Wishbone B4 memory slave for cache refills and write-backs. A single-port
// word RAM answers after a fixed number of wait states; every committed write
// is broadcast on the snoop bus so peer caches can drop stale lines.
module wb_snoop_mem_slave #(
  parameter int          ADDR_SIZE   = 8,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input logic             clk,
  input logic             rst,
  wb_snoop_mem_slave_if.slave bus
);

  localparam int TAG_LSB = ADDR_SIZE + 2;

  typedef enum logic [1:0] {IDLE, WAIT, RESP, ERR} state_t;

  state_t      state;
  logic [3:0]  cnt;

  // Request captured at the sampling edge
  logic [31:2] adr_lat;
  logic        we_lat;
  logic [3:0]  sel_lat;
  logic [31:0] dat_lat;

  logic [31:0] mem [0:(1<<ADDR_SIZE)-1];

  // Registered outputs
  logic        ack_q;
  logic        err_q;
  logic        stall_q;
  logic        snoop_valid_q;
  logic [31:0] dat_q;
  logic [31:0] snoop_addr_q;

  logic              req;
  logic              hit;
  logic              commit;
  logic [31:2]       acc_adr;
  logic              acc_we;
  logic [3:0]        acc_sel;
  logic [31:0]       acc_dat;
  logic [ADDR_SIZE-1:0] acc_idx;

  // Byte offset bits never select anything in a word RAM
  logic unused_adr_lsb;
  assign unused_adr_lsb = ^bus.adr_i[1:0];

  assign req = bus.cyc_i & bus.stb_i;
  assign hit = (bus.adr_i[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]);

  // RAM access happens on the edge that enters RESP; with no wait states that
  // edge is the sampling edge itself, so the live bus request is used.
  always_comb begin
    acc_adr = adr_lat;
    acc_we  = we_lat;
    acc_sel = sel_lat;
    acc_dat = dat_lat;
    commit  = 1'b0;
    if (state == IDLE) begin
      acc_adr = bus.adr_i[31:2];
      acc_we  = bus.we_i;
      acc_sel = bus.sel_i;
      acc_dat = bus.dat_i;
      commit  = req && hit && (WAIT_STATES == 0);
    end else if (state == WAIT) begin
      commit  = bus.cyc_i && (cnt == 4'd0);
    end
  end

  assign acc_idx = acc_adr[ADDR_SIZE+1:2];

  // Capture the request whenever one is accepted in IDLE
  always_ff @(posedge clk) begin
    if (state == IDLE && req) begin
      adr_lat <= bus.adr_i[31:2];
      we_lat  <= bus.we_i;
      sel_lat <= bus.sel_i;
      dat_lat <= bus.dat_i;
    end
  end

  // Byte-lane write into the RAM when a write commits
  always_ff @(posedge clk) begin
    if (commit && acc_we) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_sel[i]) mem[acc_idx][8*i +: 8] <= acc_dat[8*i +: 8];
      end
    end
  end

  // Transfer FSM with registered bus and snoop outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      cnt           <= 4'd0;
      ack_q         <= 1'b0;
      err_q         <= 1'b0;
      stall_q       <= 1'b0;
      snoop_valid_q <= 1'b0;
      dat_q         <= 32'd0;
      snoop_addr_q  <= 32'd0;
    end else begin
      ack_q         <= 1'b0;
      err_q         <= 1'b0;
      snoop_valid_q <= 1'b0;
      if (commit) begin
        state   <= RESP;
        ack_q   <= 1'b1;
        stall_q <= 1'b1;
        if (acc_we) begin
          snoop_valid_q <= 1'b1;
          snoop_addr_q  <= {acc_adr, 2'b00};
        end else begin
          dat_q <= mem[acc_idx];
        end
      end else begin
        case (state)
          IDLE: begin
            if (req) begin
              stall_q <= 1'b1;
              if (!hit) begin
                state <= ERR;
                err_q <= 1'b1;
              end else begin
                state <= WAIT;
                cnt   <= 4'(WAIT_STATES - 1);
              end
            end else begin
              stall_q <= 1'b0;
            end
          end
          WAIT: begin
            if (!bus.cyc_i) begin
              state   <= IDLE;
              stall_q <= 1'b0;
            end else begin
              cnt <= cnt - 4'd1;
            end
          end
          default: begin
            state   <= IDLE;
            stall_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.ack_o         = ack_q;
  assign bus.err_o         = err_q;
  assign bus.stall_o       = stall_q;
  assign bus.dat_o         = dat_q;
  assign bus.snoop_valid_o = snoop_valid_q;
  assign bus.snoop_addr_o  = snoop_addr_q;

endmodule

// File: tb/tb_wb_snoop_mem_slave.sv
// Scoreboard bench for wb_snoop_mem_slave: one instance with one wait state,
// one with three. Drivers push the expected response; per-instance monitors
// pop and compare whenever the slave presents ack, err or snoop.
module tb_wb_snoop_mem_slave;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_snoop_mem_slave_if b0 ();
  wb_snoop_mem_slave_if b1 ();

  wb_snoop_mem_slave #(.ADDR_SIZE(8), .WAIT_STATES(1), .BASE_ADDR(32'h0)) u_ws1 (
    .clk(clk), .rst(rst), .bus(b0)
  );
  wb_snoop_mem_slave #(.ADDR_SIZE(8), .WAIT_STATES(3), .BASE_ADDR(32'h0)) u_ws3 (
    .clk(clk), .rst(rst), .bus(b1)
  );

  int tests = 0;
  int fails = 0;
  int cyc_count = 0;

  always @(posedge clk) cyc_count <= cyc_count + 1;

  typedef struct {
    bit          is_err;
    bit          chk_data;
    logic [31:0] data;
    bit          snoop;
    logic [31:0] saddr;
    int          edge_no;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc_count);
    end
  endtask

  task automatic mon(input int d, input logic ack, input logic err, input logic sv,
                     input logic [31:0] dat, input logic [31:0] saddr);
    exp_t e;
    chk($sformatf("dut%0d ack/err exclusive", d), {31'd0, ack & err}, 32'd0);
    chk($sformatf("dut%0d snoop without ack", d), {31'd0, sv & ~ack}, 32'd0);
    if ((d == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
      tests++;
      fails++;
      $display("FAIL dut%0d unexpected response: ack=%b err=%b snoop=%b at cycle %0d, none expected",
               d, ack, err, sv, cyc_count);
      return;
    end
    if (d == 0) e = q0.pop_front();
    else        e = q1.pop_front();
    chk($sformatf("dut%0d err_o", d), {31'd0, err}, {31'd0, e.is_err});
    chk($sformatf("dut%0d ack_o", d), {31'd0, ack}, {31'd0, !e.is_err});
    chk($sformatf("dut%0d response edge", d), cyc_count, e.edge_no);
    chk($sformatf("dut%0d snoop_valid_o", d), {31'd0, sv}, {31'd0, e.snoop});
    if (e.snoop)    chk($sformatf("dut%0d snoop_addr_o", d), saddr, e.saddr);
    if (e.chk_data) chk($sformatf("dut%0d dat_o", d), dat, e.data);
  endtask

  // Monitor for the one-wait-state instance
  always @(negedge clk) begin
    if (rst === 1'b1 && (b0.ack_o | b0.err_o | b0.snoop_valid_o))
      mon(0, b0.ack_o, b0.err_o, b0.snoop_valid_o, b0.dat_o, b0.snoop_addr_o);
  end

  // Monitor for the three-wait-state instance
  always @(negedge clk) begin
    if (rst === 1'b1 && (b1.ack_o | b1.err_o | b1.snoop_valid_o))
      mon(1, b1.ack_o, b1.err_o, b1.snoop_valid_o, b1.dat_o, b1.snoop_addr_o);
  end

  task automatic drive(input int d, input logic cyc, input logic stb, input logic we,
                       input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    if (d == 0) begin
      b0.cyc_i = cyc; b0.stb_i = stb; b0.we_i = we;
      b0.adr_i = adr; b0.dat_i = dat; b0.sel_i = sel;
    end else begin
      b1.cyc_i = cyc; b1.stb_i = stb; b1.we_i = we;
      b1.adr_i = adr; b1.dat_i = dat; b1.sel_i = sel;
    end
  endtask

  function automatic logic stall_of(input int d);
    return (d == 0) ? b0.stall_o : b1.stall_o;
  endfunction

  function automatic logic resp_of(input int d);
    return (d == 0) ? (b0.ack_o | b0.err_o) : (b1.ack_o | b1.err_o);
  endfunction

  task automatic chk_quiet(input int d, input string name);
    if (d == 0)
      chk(name, {26'd0, b0.ack_o, b0.err_o, b0.stall_o, b0.snoop_valid_o, 2'b00} |
                b0.dat_o | b0.snoop_addr_o, 32'd0);
    else
      chk(name, {26'd0, b1.ack_o, b1.err_o, b1.stall_o, b1.snoop_valid_o, 2'b00} |
                b1.dat_o | b1.snoop_addr_o, 32'd0);
  endtask

  // One complete transfer: request, expectation push, bounded wait, release.
  task automatic xfer(input int d, input logic we, input logic [31:0] adr,
                      input logic [31:0] dat, input logic [3:0] sel,
                      input bit exp_err, input bit chk_data, input logic [31:0] exp_data);
    exp_t e;
    int   ws;
    int   n;
    ws = (d == 0) ? 1 : 3;
    @(negedge clk);
    drive(d, 1'b1, 1'b1, we, adr, dat, sel);
    e.is_err   = exp_err;
    e.chk_data = chk_data;
    e.data     = exp_data;
    e.snoop    = we && !exp_err;
    e.saddr    = {adr[31:2], 2'b00};
    e.edge_no  = cyc_count + 1 + (exp_err ? 0 : ws);
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
    @(negedge clk);
    drive(d, 1'b1, 1'b0, we, adr, dat, sel);
    chk($sformatf("dut%0d stall after sample", d), {31'd0, stall_of(d)}, 32'd1);
    n = 0;
    while (!resp_of(d) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!resp_of(d)) begin
      tests++;
      fails++;
      $display("FAIL dut%0d response timeout: none after 20 cycles, ack or err required", d);
    end
    drive(d, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
  endtask

  initial begin
    rst = 1'b0;
    drive(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    drive(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    repeat (3) @(negedge clk);
    chk_quiet(0, "dut0 reset outputs");
    chk_quiet(1, "dut1 reset outputs");
    rst = 1'b1;
    @(negedge clk);

    // Basic read, then full-word write and read-back
    xfer(0, 1'b0, 32'h0000_0010, 32'h0, 4'hF, 1'b0, 1'b0, 32'h0);
    xfer(0, 1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b0, 32'h0);
    xfer(0, 1'b0, 32'h0000_0020, 32'h0, 4'hF, 1'b0, 1'b1, 32'hDEAD_BEEF);

    // Partial-lane write merges with the old word
    xfer(0, 1'b1, 32'h0000_0020, 32'h1122_3344, 4'b0101, 1'b0, 1'b0, 32'h0);
    xfer(0, 1'b0, 32'h0000_0020, 32'h0, 4'hF, 1'b0, 1'b1, 32'hDE22_BE44);

    // Out-of-window accesses error and leave the aliased word alone
    xfer(0, 1'b0, 32'h0000_0400, 32'h0, 4'hF, 1'b1, 1'b0, 32'h0);
    xfer(0, 1'b1, 32'h0000_0420, 32'hFFFF_FFFF, 4'hF, 1'b1, 1'b0, 32'h0);
    xfer(0, 1'b0, 32'h0000_0020, 32'h0, 4'hF, 1'b0, 1'b1, 32'hDE22_BE44);

    // Strobe without cycle is ignored; byte offset bits do not matter
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 1'b1, 32'h0000_0020, 32'h0, 4'hF);
    repeat (2) @(negedge clk);
    chk("dut0 stall on stb without cyc", {31'd0, b0.stall_o}, 32'd0);
    drive(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    xfer(0, 1'b0, 32'h0000_0023, 32'h0, 4'hF, 1'b0, 1'b1, 32'hDE22_BE44);

    // Three wait states: write, read, sel=0 write, abort in WAIT
    xfer(1, 1'b1, 32'h0000_0030, 32'hCAFE_F00D, 4'hF, 1'b0, 1'b0, 32'h0);
    xfer(1, 1'b0, 32'h0000_0030, 32'h0, 4'hF, 1'b0, 1'b1, 32'hCAFE_F00D);
    xfer(1, 1'b1, 32'h0000_0030, 32'h1234_5678, 4'h0, 1'b0, 1'b0, 32'h0);
    xfer(1, 1'b0, 32'h0000_0030, 32'h0, 4'hF, 1'b0, 1'b1, 32'hCAFE_F00D);
    @(negedge clk);
    drive(1, 1'b1, 1'b1, 1'b1, 32'h0000_0030, 32'h0BAD_C0DE, 4'hF);
    @(negedge clk);
    drive(1, 1'b1, 1'b0, 1'b1, 32'h0000_0030, 32'h0BAD_C0DE, 4'hF);
    @(negedge clk);
    drive(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    @(negedge clk);
    chk("dut1 stall after abort", {31'd0, b1.stall_o}, 32'd0);
    repeat (4) @(negedge clk);
    xfer(1, 1'b0, 32'h0000_0030, 32'h0, 4'hF, 1'b0, 1'b1, 32'hCAFE_F00D);

    // Reset asserted while waiting, then a normal read
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 1'b0, 32'h0000_0020, 32'h0, 4'hF);
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 1'b0, 32'h0000_0020, 32'h0, 4'hF);
    chk("dut0 stall before reset", {31'd0, b0.stall_o}, 32'd1);
    rst = 1'b0;
    #1;
    chk_quiet(0, "dut0 outputs in mid-transfer reset");
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    @(negedge clk);
    rst = 1'b1;
    xfer(0, 1'b0, 32'h0000_0020, 32'h0, 4'hF, 1'b0, 1'b1, 32'hDE22_BE44);

    repeat (4) @(negedge clk);
    chk("dut0 responses outstanding", q0.size(), 32'd0);
    chk("dut1 responses outstanding", q1.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
